// File: rtl/draw_command_engine.sv
// Draw command engine: assembles multi-byte drawing commands from the UART receiver
// and streams the resulting rectangle of pixel writes to the framebuffer with back-pressure.
module draw_command_engine #(
  parameter int BITS_PER_PIXEL = 3,
  parameter int FB_WIDTH       = 640,
  parameter int FB_HEIGHT      = 480,
  parameter int ADDR_WIDTH     = 19
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_n,
  input  logic                      i_Rx_DV,
  input  logic [7:0]                i_Rx_Byte,
  input  logic                      i_Write_Ready,
  output logic                      o_Write_Enable,
  output logic [ADDR_WIDTH-1:0]     o_Write_Addr,
  output logic [BITS_PER_PIXEL-1:0] o_Write_Data,
  output logic                      o_Busy,
  output logic                      o_Error,
  output logic                      o_Dropped
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OPERANDS = 2'd1,
    ST_SETUP    = 2'd2,
    ST_EXECUTE  = 2'd3
  } state_t;

  localparam logic [1:0]            OP_FILL  = 2'd1;
  localparam logic [1:0]            OP_PIXEL = 2'd2;
  localparam logic [1:0]            OP_RECT  = 2'd3;
  localparam logic [15:0]           X_LAST   = 16'(FB_WIDTH - 1);
  localparam logic [15:0]           Y_LAST   = 16'(FB_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_WIDTH);

  function automatic logic [3:0] operand_count(input logic [1:0] op);
    case (op)
      OP_FILL:  return 4'd1;
      OP_PIXEL: return 4'd5;
      OP_RECT:  return 4'd9;
      default:  return 4'd0;
    endcase
  endfunction

  state_t                    state_q, state_d;
  logic [1:0]                opcode_q, opcode_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [7:0][7:0]           ops_q, ops_d;
  logic [BITS_PER_PIXEL-1:0] col_q, col_d;
  logic [15:0]               x_q, x_d, y_q, y_d, x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d, addr_q, addr_d;
  logic [BITS_PER_PIXEL-1:0] data_q, data_d;
  logic                      we_q, we_d, err_q, err_d, drop_q, drop_d;

  logic [15:0]               sx0_s, sy0_s, sx1_s, sy1_s;
  logic                      sbad_s;
  logic [ADDR_WIDTH-1:0]     sbase_s;

  // Decode the buffered operands into an inclusive rectangle and validate it.
  always_comb begin
    sx0_s = 16'd0;
    sy0_s = 16'd0;
    sx1_s = 16'd0;
    sy1_s = 16'd0;
    case (opcode_q)
      OP_FILL: begin
        sx1_s = X_LAST;
        sy1_s = Y_LAST;
      end
      OP_PIXEL: begin
        sx0_s = {ops_q[1], ops_q[0]};
        sy0_s = {ops_q[3], ops_q[2]};
        sx1_s = sx0_s;
        sy1_s = sy0_s;
      end
      OP_RECT: begin
        sx0_s = {ops_q[1], ops_q[0]};
        sy0_s = {ops_q[3], ops_q[2]};
        sx1_s = {ops_q[5], ops_q[4]};
        sy1_s = {ops_q[7], ops_q[6]};
      end
      default: begin
        sx0_s = 16'd1;
      end
    endcase
    sbad_s  = (sx0_s > sx1_s) || (sy0_s > sy1_s) || (sx1_s > X_LAST) || (sy1_s > Y_LAST);
    // One multiply per command; the walk itself only adds.
    sbase_s = ADDR_WIDTH'(sy0_s) * ROW_STEP;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cnt_d    = cnt_q;
    ops_d    = ops_q;
    col_d    = col_q;
    x_d      = x_q;
    y_d      = y_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    base_d   = base_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    err_d    = 1'b0;
    drop_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Rx_DV) begin
          case (i_Rx_Byte)
            8'h00: state_d = ST_IDLE;
            8'h01, 8'h02, 8'h03: begin
              opcode_d = i_Rx_Byte[1:0];
              cnt_d    = 4'd0;
              state_d  = ST_OPERANDS;
            end
            default: err_d = 1'b1;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OPERANDS: begin
        if (cnt_q == operand_count(opcode_q)) begin
          // Command complete; anything arriving now belongs to no command.
          drop_d  = i_Rx_DV;
          state_d = ST_SETUP;
        end else if (i_Rx_DV) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == operand_count(opcode_q) - 4'd1) begin
            col_d = i_Rx_Byte[BITS_PER_PIXEL-1:0];
          end else begin
            for (int i = 0; i < 8; i++) begin
              if (cnt_q == 4'(i)) ops_d[i] = i_Rx_Byte;
            end
          end
        end else begin
          state_d = ST_OPERANDS;
        end
      end
      ST_SETUP: begin
        drop_d = i_Rx_DV;
        if (sbad_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          x_d     = sx0_s;
          y_d     = sy0_s;
          x0_d    = sx0_s;
          x1_d    = sx1_s;
          y1_d    = sy1_s;
          base_d  = sbase_s;
          addr_d  = sbase_s + ADDR_WIDTH'(sx0_s);
          data_d  = col_q;
          we_d    = 1'b1;
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        drop_d = i_Rx_DV;
        if (i_Write_Ready) begin
          if (x_q != x1_q) begin
            x_d    = x_q + 16'd1;
            addr_d = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end else if (y_q != y1_q) begin
            x_d    = x0_q;
            y_d    = y_q + 16'd1;
            base_d = base_q + ROW_STEP;
            addr_d = base_q + ROW_STEP + ADDR_WIDTH'(x0_q);
          end else begin
            we_d    = 1'b0;
            addr_d  = {ADDR_WIDTH{1'b0}};
            data_d  = {BITS_PER_PIXEL{1'b0}};
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      default: begin
        we_d    = 1'b0;
        addr_d  = {ADDR_WIDTH{1'b0}};
        data_d  = {BITS_PER_PIXEL{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= 2'd0;
      cnt_q    <= 4'd0;
      ops_q    <= '0;
      col_q    <= {BITS_PER_PIXEL{1'b0}};
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      x0_q     <= 16'd0;
      x1_q     <= 16'd0;
      y1_q     <= 16'd0;
      base_q   <= {ADDR_WIDTH{1'b0}};
      addr_q   <= {ADDR_WIDTH{1'b0}};
      data_q   <= {BITS_PER_PIXEL{1'b0}};
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
      ops_q    <= ops_d;
      col_q    <= col_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  assign o_Write_Enable = we_q;
  assign o_Write_Addr   = addr_q;
  assign o_Write_Data   = data_q;
  assign o_Busy         = (state_q != ST_IDLE);
  assign o_Error        = err_q;
  assign o_Dropped      = drop_q;

endmodule
